// File: rtl/paddle_if.sv
// -----------------------------------------------------------------------------
// paddle_if : signal bundle between the Breakout frame logic and paddle_ctrl.
//
//   frame_tick  one-cycle pulse per video frame
//   start       active-low start button
//   L, R        active-low move-left / move-right buttons
//   ballx       ball left x
//   bally       ball bottom row
//   padx        paddle left x
//   pady        paddle top row (constant)
//   pad_col     one-cycle ball/paddle collision pulse
//   pad_ang     zone index of the last collision, 0 = leftmost
//   speed       current paddle speed in pixels/frame
//
// master drives the buttons/ball position, slave (paddle_ctrl) drives the paddle.
// -----------------------------------------------------------------------------
interface paddle_if;
   logic       frame_tick;
   logic       start;
   logic       L;
   logic       R;
   logic [9:0] ballx;
   logic [9:0] bally;
   logic [9:0] padx;
   logic [9:0] pady;
   logic       pad_col;
   logic [2:0] pad_ang;
   logic [3:0] speed;

   modport master (
      output frame_tick, start, L, R, ballx, bally,
      input  padx, pady, pad_col, pad_ang, speed
   );

   modport slave (
      input  frame_tick, start, L, R, ballx, bally,
      output padx, pady, pad_col, pad_ang, speed
   );
endinterface

// File: rtl/paddle_ctrl.sv
// -----------------------------------------------------------------------------
// paddle_ctrl : Breakout paddle controller.
//
// Moves the paddle from the active-low L/R buttons once per frame_tick, clamps
// it to the playfield, and reports ball/paddle contact as a one-shot pulse plus
// the zone index used by the ball-motion block to choose the rebound angle.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   pif   paddle_if.slave (frame_tick, start, L, R, ballx, bally in;
//         padx, pady, pad_col, pad_ang, speed out)
//
// Build option:
//   PADDLE_ACCEL_EN  when defined, speed rises by one every ACCEL_FRAMES ticks
//                    of continuous movement, saturating at MAX_SPEED. When
//                    undefined, speed is fixed at 1 and no hold counter exists.
// -----------------------------------------------------------------------------
module paddle_ctrl #(
   parameter int SCREEN_W     = 320,
   parameter int PAD_Y        = 200,
   parameter int PAD_START_X  = 100,
   parameter int ZONE_W       = 16,
   parameter int ZONES        = 5,
   parameter int MAX_SPEED    = 4,
   parameter int ACCEL_FRAMES = 8
) (
   input logic     clk,
   input logic     rst,
   paddle_if.slave pif
);

   localparam int          PAD_W = ZONES * ZONE_W;
   localparam logic [10:0] X_MAX = 11'(SCREEN_W - PAD_W);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] READY  = 2'd1;
   localparam logic [1:0] MOVE_L = 2'd2;
   localparam logic [1:0] MOVE_R = 2'd3;

   if (ZONES < 1 || ZONES > 8 || MAX_SPEED < 1 || MAX_SPEED > 15 ||
       ACCEL_FRAMES < 1) begin : g_param_check
      $error("paddle_ctrl: parameter out of range");
   end

   logic [1:0]  state;
   logic [9:0]  padx_r;
   logic        pad_col_r;
   logic [2:0]  pad_ang_r;
   logic        supp;
   logic [3:0]  step;

   logic [10:0] bx11;
   logic [10:0] px11;
   logic [10:0] sum_r;
   logic [9:0]  left_x;
   logic [9:0]  right_x;
   logic        hit;
   logic [2:0]  zone;
   logic        l_dn;
   logic        r_dn;

   // Hit test, zone comparators and clamped move targets, all on pre-move padx.
   // 11-bit sums keep padx + PAD_W and padx + step from wrapping.
   always_comb begin
      bx11  = {1'b0, pif.ballx};
      px11  = {1'b0, padx_r};
      l_dn  = ~pif.L;
      r_dn  = ~pif.R;
      hit   = (pif.bally == 10'(PAD_Y)) && (bx11 >= px11) &&
              (bx11 <= px11 + 11'(PAD_W - 1));
      // Zone = number of zone boundaries the ball is at or past.
      zone  = '0;
      for (int k = 1; k < ZONES; k++) begin
         if (bx11 >= px11 + 11'(k * ZONE_W)) zone = 3'(k);
      end
      sum_r   = px11 + {7'd0, step};
      right_x = (sum_r > X_MAX) ? X_MAX[9:0] : sum_r[9:0];
      left_x  = ({6'd0, step} > padx_r) ? 10'd0 : padx_r - {6'd0, step};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         padx_r    <= 10'(PAD_START_X);
         pad_col_r <= 1'b0;
         pad_ang_r <= 3'd0;
         supp      <= 1'b0;
      end else begin
         pad_col_r <= 1'b0;
         if (pif.frame_tick) begin
            // Re-arm once the ball has left the paddle row; a hit implies
            // bally == PAD_Y, so the two assignments never collide.
            if (pif.bally != 10'(PAD_Y)) supp <= 1'b0;
            if (state != IDLE && hit && !supp) begin
               pad_col_r <= 1'b1;
               pad_ang_r <= zone;
               supp      <= 1'b1;
            end
            case (state)
               IDLE: begin
                  if (!pif.start) begin
                     state  <= READY;
                     padx_r <= 10'(PAD_START_X);
                  end
               end
               READY: begin
                  if (l_dn && !r_dn)      state <= MOVE_L;
                  else if (r_dn && !l_dn) state <= MOVE_R;
               end
               MOVE_L: begin
                  padx_r <= left_x;
                  if (!l_dn || r_dn) state <= READY;
               end
               default: begin
                  padx_r <= right_x;
                  if (!r_dn || l_dn) state <= READY;
               end
            endcase
         end
      end
   end

`ifdef PADDLE_ACCEL_EN
   localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);

   logic [CNT_W-1:0] hold_cnt;
   logic [3:0]       speed_r;
   logic             to_ready;
   logic             moving_on;

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : s + 4'd1;
   endfunction

   always_comb begin
      to_ready  = (state == IDLE   && !pif.start) ||
                  (state == MOVE_L && (!l_dn || r_dn)) ||
                  (state == MOVE_R && (!r_dn || l_dn));
      moving_on = (state == MOVE_L || state == MOVE_R) && !to_ready;
   end

   // Speed used on a tick is the value before that tick's update, so the
   // first step-up takes effect on tick ACCEL_FRAMES+1 of the hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         speed_r  <= 4'd1;
      end else if (pif.frame_tick) begin
         if (to_ready) begin
            hold_cnt <= '0;
            speed_r  <= 4'd1;
         end else if (moving_on) begin
            if (hold_cnt == CNT_W'(ACCEL_FRAMES - 1)) begin
               hold_cnt <= '0;
               speed_r  <= sat_inc(speed_r);
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end
   end

   assign step = speed_r;
`else
   assign step = 4'd1;
`endif

   assign pif.padx    = padx_r;
   assign pif.pady    = 10'(PAD_Y);
   assign pif.pad_col = pad_col_r;
   assign pif.pad_ang = pad_ang_r;
   assign pif.speed   = step;

endmodule
